// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target: FSM state encoding and bus-level constants.
package i2c_pkg;

    // Protocol phase of the target, one value per byte/ACK slot kind.
    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WRITE,
        WRITE_ACK,
        READ,
        READ_ACK,
        IGNORE
    } i2c_state_e;

    // R/W bit value that selects a read (target -> initiator) transfer.
    localparam logic I2C_RW_READ = 1'b1;
    // SDA level that means acknowledge in the ninth bit slot.
    localparam logic I2C_ACK     = 1'b0;
    // Number of data bits in one byte slot.
    localparam logic [3:0] I2C_BYTE_BITS = 4'd8;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchroniser and edge detector for one open-drain I2C line (SCL or SDA).
// The chain and the edge-compare flop preset to 1, the idle level of a pulled-up line,
// so leaving reset never produces a spurious edge.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Move the pin level through the synchroniser and keep last cycle's level for edge compare.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = level_o & ~prev_q;
    assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/i2c_target.sv
// I2C target: detects START/STOP, matches a 7-bit address, ACKs, and moves bytes
// to and from a byte-level host port. Never stretches SCL.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] ADDRESS     = 7'h3C,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_low,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_first,
    output logic       tx_req,
    input  logic [7:0] tx_data,
    output logic       busy,
    output logic       nack_seen
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;
    logic start_det, stop_det;
    logic [7:0] shift_in;

    i2c_state_e state_q;
    logic [3:0] cnt_q;
    logic [7:0] shift_q;
    logic       ack_phase_q;   // 0: waiting for the fall that opens the ACK slot, 1: for the one that closes it
    logic       rw_q;
    logic       first_q;
    logic       sda_low_q;
    logic [7:0] rx_data_q;
    logic       rx_valid_q;
    logic       rx_first_q;
    logic       tx_req_q;
    logic       busy_q;
    logic       nack_q;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
        .clk     (clk),
        .reset   (reset),
        .pin_i   (scl_in),
        .level_o (scl_lvl),
        .rise_o  (scl_rise),
        .fall_o  (scl_fall)
    );

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
        .clk     (clk),
        .reset   (reset),
        .pin_i   (sda_in),
        .level_o (sda_lvl),
        .rise_o  (sda_rise),
        .fall_o  (sda_fall)
    );

    // Bus conditions: SDA moving while SCL is high is never data.
    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;
    assign shift_in  = {shift_q[6:0], sda_lvl};

    // Protocol FSM with registered bus and host outputs; START/STOP override every state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            ack_phase_q <= 1'b0;
            rw_q        <= 1'b0;
            first_q     <= 1'b0;
            sda_low_q   <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            rx_first_q  <= 1'b0;
            tx_req_q    <= 1'b0;
            busy_q      <= 1'b0;
            nack_q      <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            nack_q     <= 1'b0;

            // The host answers tx_req with the next read byte one cycle later.
            if (tx_req_q) begin
                shift_q <= tx_data;
            end

            if (start_det) begin
                // busy is held here and re-decided by the address byte that follows.
                state_q     <= ADDR;
                cnt_q       <= '0;
                ack_phase_q <= 1'b0;
                sda_low_q   <= 1'b0;
            end else if (stop_det) begin
                state_q     <= IDLE;
                cnt_q       <= '0;
                ack_phase_q <= 1'b0;
                sda_low_q   <= 1'b0;
                busy_q      <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        sda_low_q <= 1'b0;
                    end

                    ADDR: begin
                        if (scl_rise) begin
                            shift_q <= shift_in;
                            cnt_q   <= cnt_q + 4'd1;
                            if (cnt_q == I2C_BYTE_BITS - 4'd1) begin
                                cnt_q <= '0;
                                if (shift_q[6:0] == ADDRESS) begin
                                    state_q     <= ADDR_ACK;
                                    ack_phase_q <= 1'b0;
                                    busy_q      <= 1'b1;
                                    rw_q        <= sda_lvl;
                                    first_q     <= 1'b1;
                                end else begin
                                    state_q <= IGNORE;
                                    busy_q  <= 1'b0;
                                end
                            end
                        end
                    end

                    ADDR_ACK: begin
                        if (scl_fall) begin
                            if (!ack_phase_q) begin
                                sda_low_q   <= 1'b1;
                                ack_phase_q <= 1'b1;
                                if (rw_q == I2C_RW_READ) begin
                                    tx_req_q <= 1'b1;
                                end
                            end else begin
                                ack_phase_q <= 1'b0;
                                if (rw_q == I2C_RW_READ) begin
                                    sda_low_q <= ~shift_q[7];
                                    shift_q   <= {shift_q[6:0], 1'b0};
                                    cnt_q     <= 4'd1;
                                    state_q   <= READ;
                                end else begin
                                    sda_low_q <= 1'b0;
                                    cnt_q     <= '0;
                                    state_q   <= WRITE;
                                end
                            end
                        end
                    end

                    WRITE: begin
                        if (scl_rise) begin
                            shift_q <= shift_in;
                            cnt_q   <= cnt_q + 4'd1;
                            if (cnt_q == I2C_BYTE_BITS - 4'd1) begin
                                cnt_q       <= '0;
                                rx_data_q   <= shift_in;
                                rx_valid_q  <= 1'b1;
                                rx_first_q  <= first_q;
                                first_q     <= 1'b0;
                                ack_phase_q <= 1'b0;
                                state_q     <= WRITE_ACK;
                            end
                        end
                    end

                    WRITE_ACK: begin
                        if (scl_fall) begin
                            if (!ack_phase_q) begin
                                sda_low_q   <= 1'b1;
                                ack_phase_q <= 1'b1;
                            end else begin
                                sda_low_q   <= 1'b0;
                                ack_phase_q <= 1'b0;
                                cnt_q       <= '0;
                                state_q     <= WRITE;
                            end
                        end
                    end

                    READ: begin
                        if (scl_fall) begin
                            if (cnt_q == I2C_BYTE_BITS) begin
                                sda_low_q   <= 1'b0;
                                ack_phase_q <= 1'b0;
                                state_q     <= READ_ACK;
                            end else begin
                                sda_low_q <= ~shift_q[7];
                                shift_q   <= {shift_q[6:0], 1'b0};
                                cnt_q     <= cnt_q + 4'd1;
                            end
                        end
                    end

                    READ_ACK: begin
                        if (!ack_phase_q) begin
                            if (scl_rise) begin
                                if (sda_lvl == I2C_ACK) begin
                                    tx_req_q    <= 1'b1;
                                    ack_phase_q <= 1'b1;
                                end else begin
                                    nack_q    <= 1'b1;
                                    sda_low_q <= 1'b0;
                                    state_q   <= IGNORE;
                                end
                            end
                        end else if (scl_fall) begin
                            sda_low_q   <= ~shift_q[7];
                            shift_q     <= {shift_q[6:0], 1'b0};
                            cnt_q       <= 4'd1;
                            ack_phase_q <= 1'b0;
                            state_q     <= READ;
                        end
                    end

                    IGNORE: begin
                        sda_low_q <= 1'b0;
                    end

                    default: begin
                        state_q   <= IDLE;
                        sda_low_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sda_low   = sda_low_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign rx_first  = rx_first_q;
    assign tx_req    = tx_req_q;
    assign busy      = busy_q;
    assign nack_seen = nack_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged initiator on an open-drain bus, table-driven and
// randomized transactions checked against a transaction-level expectation model.
`timescale 1ns/1ps
module tb_i2c_target;

    localparam logic [6:0] TGT = 7'h3C;
    localparam int Q = 8;   // clk cycles per quarter SCL period

    typedef struct packed {
        logic [6:0]  addr;
        logic        rw;
        logic [2:0]  nbytes;
        logic [31:0] data;     // byte i in data[8*i +: 8]
        logic        exp_ack;  // target expected to claim the transfer
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       scl_m, sda_m;
    logic       scl_in, sda_in;
    logic       sda_low, rx_valid, rx_first, tx_req, busy, nack_seen;
    logic [7:0] rx_data;
    logic [7:0] tx_data = 8'h00;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] rxq[$];
    logic       rxf[$];
    logic [7:0] txq[$];
    int         tx_req_cnt = 0;
    int         nack_cnt = 0;
    logic       low_seen = 1'b0;

    always #5 clk = ~clk;

    assign scl_in = scl_m;
    assign sda_in = sda_m & ~sda_low;

    i2c_target #(.ADDRESS(TGT), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .sda_low   (sda_low),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_first  (rx_first),
        .tx_req    (tx_req),
        .tx_data   (tx_data),
        .busy      (busy),
        .nack_seen (nack_seen)
    );

    // Host-side observer and read-data responder.
    initial begin
        forever begin
            @(negedge clk);
            if (rx_valid === 1'b1) begin
                rxq.push_back(rx_data);
                rxf.push_back(rx_first);
            end
            if (tx_req === 1'b1) begin
                tx_req_cnt++;
                tx_data = (txq.size() > 0) ? txq.pop_front() : 8'hFF;
            end
            if (nack_seen === 1'b1) nack_cnt++;
            if (sda_low === 1'b1) low_seen = 1'b1;
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic model_ack(input logic [6:0] a);
        return a == TGT;
    endfunction

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic put_bit(input logic b);
        sda_m = b;    wait_q();
        scl_m = 1'b1; wait_q();
        wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic get_bit(output logic b);
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        b = sda_in;   wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b1; wait_q();
    endtask

    task automatic send_byte(input logic [7:0] b, output logic nak);
        for (int i = 7; i >= 0; i--) put_bit(b[i]);
        get_bit(nak);
    endtask

    task automatic recv_byte(output logic [7:0] b);
        logic bi;
        for (int i = 7; i >= 0; i--) begin
            get_bit(bi);
            b[i] = bi;
        end
    endtask

    task automatic clear_obs();
        rxq.delete();
        rxf.delete();
        txq.delete();
        tx_req_cnt = 0;
        nack_cnt   = 0;
        low_seen   = 1'b0;
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        logic       nak;
        logic [7:0] got;
        int         n;
        n = int'(v.nbytes);
        clear_obs();
        if (v.rw) for (int i = 0; i < n; i++) txq.push_back(v.data[8*i +: 8]);
        i2c_start();
        send_byte({v.addr, v.rw}, nak);
        check($sformatf("%s addr-ack", tag), 32'(nak), 32'(!v.exp_ack));
        check($sformatf("%s busy", tag), 32'(busy), 32'(v.exp_ack));
        for (int i = 0; i < n; i++) begin
            if (!v.rw) begin
                send_byte(v.data[8*i +: 8], nak);
                check($sformatf("%s wr-ack%0d", tag, i), 32'(nak), 32'(!v.exp_ack));
            end else begin
                recv_byte(got);
                check($sformatf("%s rd%0d", tag, i), 32'(got),
                      v.exp_ack ? 32'(v.data[8*i +: 8]) : 32'hFF);
                put_bit(i == n - 1);
            end
        end
        if (v.rw) check($sformatf("%s released", tag), 32'(sda_low), 32'd0);
        i2c_stop();
        wait_q();
        check($sformatf("%s busy-end", tag), 32'(busy), 32'd0);
        check($sformatf("%s low-seen", tag), 32'(low_seen), 32'(v.exp_ack));
        if (!v.rw) begin
            check($sformatf("%s rx-count", tag), 32'(rxq.size()), v.exp_ack ? 32'(n) : 32'd0);
            if (v.exp_ack && rxq.size() == n) begin
                for (int i = 0; i < n; i++) begin
                    check($sformatf("%s rx%0d", tag, i), 32'(rxq[i]), 32'(v.data[8*i +: 8]));
                    check($sformatf("%s first%0d", tag, i), 32'(rxf[i]), 32'(i == 0));
                end
            end
        end else begin
            check($sformatf("%s tx-req", tag), 32'(tx_req_cnt), v.exp_ack ? 32'(n) : 32'd0);
            check($sformatf("%s nack", tag), 32'(nack_cnt), v.exp_ack ? 32'd1 : 32'd0);
        end
    endtask

    vec_t tbl[6];

    initial begin
        logic       nak;
        logic       bi;
        logic [7:0] got;
        vec_t       v;

        tbl[0] = '{addr: 7'h3C, rw: 1'b0, nbytes: 3'd2, data: 32'h00005AA5, exp_ack: 1'b1};
        tbl[1] = '{addr: 7'h3D, rw: 1'b0, nbytes: 3'd1, data: 32'h00000011, exp_ack: 1'b0};
        tbl[2] = '{addr: 7'h3C, rw: 1'b1, nbytes: 3'd2, data: 32'h000081C3, exp_ack: 1'b1};
        tbl[3] = '{addr: 7'h00, rw: 1'b0, nbytes: 3'd1, data: 32'h00000055, exp_ack: 1'b0};
        tbl[4] = '{addr: 7'h3C, rw: 1'b0, nbytes: 3'd3, data: 32'h0000FF00, exp_ack: 1'b1};
        tbl[5] = '{addr: 7'h1E, rw: 1'b1, nbytes: 3'd1, data: 32'h0000003C, exp_ack: 1'b0};

        reset = 1'b1;
        scl_m = 1'b1;
        sda_m = 1'b1;
        repeat (4) @(negedge clk);
        check("reset sda_low", 32'(sda_low), 32'd0);
        check("reset rx_valid", 32'(rx_valid), 32'd0);
        check("reset rx_data", 32'(rx_data), 32'd0);
        check("reset rx_first", 32'(rx_first), 32'd0);
        check("reset tx_req", 32'(tx_req), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset nack_seen", 32'(nack_seen), 32'd0);
        reset = 1'b0;
        wait_q();
        check("idle busy", 32'(busy), 32'd0);

        for (int k = 0; k < 6; k++) run_txn(tbl[k], $sformatf("tbl%0d", k));

        // Write register byte, repeated START, read one byte back.
        clear_obs();
        txq.push_back(8'h42);
        i2c_start();
        send_byte({TGT, 1'b0}, nak);
        check("rs addr-w ack", 32'(nak), 32'd0);
        send_byte(8'h07, nak);
        check("rs reg ack", 32'(nak), 32'd0);
        i2c_start();
        check("rs busy held", 32'(busy), 32'd1);
        send_byte({TGT, 1'b1}, nak);
        check("rs addr-r ack", 32'(nak), 32'd0);
        check("rs busy read", 32'(busy), 32'd1);
        recv_byte(got);
        check("rs read data", 32'(got), 32'h42);
        put_bit(1'b1);
        i2c_stop();
        wait_q();
        check("rs rx-count", 32'(rxq.size()), 32'd1);
        if (rxq.size() == 1) begin
            check("rs rx0", 32'(rxq[0]), 32'h07);
            check("rs first0", 32'(rxf[0]), 32'd1);
        end
        check("rs tx-req", 32'(tx_req_cnt), 32'd1);
        check("rs nack", 32'(nack_cnt), 32'd1);
        check("rs busy-end", 32'(busy), 32'd0);

        // Reset while the target drives bit 4 of a read byte.
        clear_obs();
        txq.push_back(8'h00);
        i2c_start();
        send_byte({TGT, 1'b1}, nak);
        check("rst addr ack", 32'(nak), 32'd0);
        for (int i = 0; i < 3; i++) get_bit(bi);
        check("rst driving bit4", 32'(sda_low), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("rst sda released", 32'(sda_low), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        scl_m = 1'b1;
        sda_m = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        wait_q();
        run_txn(tbl[0], "post-reset");

        // STOP after three address bits aborts silently.
        clear_obs();
        i2c_start();
        put_bit(1'b0);
        put_bit(1'b1);
        put_bit(1'b1);
        i2c_stop();
        wait_q();
        check("abort low-seen", 32'(low_seen), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        run_txn(tbl[4], "post-abort");

        // Randomized transactions.
        for (int k = 0; k < 10; k++) begin
            v.addr    = ($urandom_range(0, 1) == 1) ? TGT : 7'($urandom);
            v.rw      = 1'($urandom);
            v.nbytes  = 3'($urandom_range(1, 3));
            v.data    = $urandom;
            v.exp_ack = model_ack(v.addr);
            run_txn(v, $sformatf("rnd%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
